// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
// Covers FSM state encoding, requester port indices and default memory geometry.
package dmem_pkg;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int unsigned PORT_CPU = 0;
  localparam int unsigned PORT_DBG = 1;

  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_DATA_W = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic, purely combinational.
// last_gnt (0 = CPU, 1 = DBG) is held by the parent and only breaks ties.
module rr_arbiter2
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (en) begin
      if (req[PORT_CPU] && req[PORT_DBG]) begin
        if (last_gnt) gnt[PORT_CPU] = 1'b1;
        else          gnt[PORT_DBG] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the CPU and debug ports, one transfer per cycle,
// with a sequencer that sweeps every word to CLEAR_VALUE.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned       ADDR_W      = DEF_ADDR_W,
  parameter int unsigned       DATA_W      = DEF_DATA_W,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dbg_valid,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              last_gnt;
  logic [1:0]        gnt;

  rr_arbiter2 u_arb (
    .req      ({dbg_valid, cpu_valid}),
    .last_gnt (last_gnt),
    .en       (state == ST_ARB),
    .gnt      (gnt)
  );

  assign cpu_ready  = gnt[PORT_CPU];
  assign dbg_ready  = gnt[PORT_DBG];
  assign clear_busy = (state == ST_CLEAR);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clr_cnt;
      mem_wdata = CLEAR_VALUE;
    end else if (gnt[PORT_CPU]) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (gnt[PORT_DBG]) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // Clear sweep FSM; clear_done marks the first ARB cycle after the last sweep write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_ARB;
      clr_cnt    <= '0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        ST_ARB: begin
          if (clear_start) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == '1) begin
            state      <= ST_ARB;
            clear_done <= 1'b1;
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt   <= 1'b1;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
    end else begin
      if (gnt[PORT_CPU])      last_gnt <= 1'b0;
      else if (gnt[PORT_DBG]) last_gnt <= 1'b1;

      cpu_rvalid <= gnt[PORT_CPU] & ~cpu_we;
      dbg_rvalid <= gnt[PORT_DBG] & ~dbg_we;
      if (gnt[PORT_CPU] && !cpu_we) cpu_rdata <= mem_rdata;
      if (gnt[PORT_DBG] && !dbg_we) dbg_rdata <= mem_rdata;
    end
  end

endmodule
